// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase-accumulator front end for the sine_func lookup stage.
//
// A prescaler produces a sample tick every div+1 enabled clocks. On each tick
// the tuning word is added to the phase accumulator. The top PHASE_W bits plus
// poff are presented on x, with a one-clock x_stb pulse. y_stb repeats x_stb
// SINE_LAT clocks later, which is when sine_func's y output is valid.
//
// Tuning words enter through a valid/ready handshake into a single pending
// buffer. They are promoted to the active word only on a tick, so the
// frequency changes on sample boundaries.
//
// Optional build macro DDS_SWEEP_EN adds a linear frequency sweep engine.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable; 0 freezes prescaler and accumulator
//   div           prescaler divide value (tick every div+1 clocks)
//   ftw_in/ftw_valid/ftw_ready   tuning-word handshake
//   poff          phase offset added to the output phase (sampled on ticks)
//   sync          clears accumulator and prescaler, suppresses that tick
//   x, x_stb      phase word to sine_func and its update strobe
//   y_stb         sine_func y-valid strobe (x_stb delayed SINE_LAT clocks)
//   wrap          accumulator overflow on this sample
//   sweep_step/sweep_end/sweep_start/sweep_busy/sweep_done  (DDS_SWEEP_EN only)
module dds_phase_gen #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned PHASE_W  = 10,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned SINE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   div,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] poff,
  input  logic               sync,
  output logic [PHASE_W-1:0] x,
  output logic               x_stb,
  output logic               y_stb,
  output logic               wrap
`ifdef DDS_SWEEP_EN
  ,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [ACC_W-1:0]   sweep_end,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done
`endif
);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    ftw_act;
  logic [ACC_W-1:0]    ftw_pend;
  logic                pend_full;
  logic [DIV_W-1:0]    cnt;
  logic [SINE_LAT-1:0] stb_dly;
  logic [ACC_W:0]      acc_sum;
  logic                tick;
  logic                capture;
  logic                promote;
  logic                busy;

`ifdef DDS_SWEEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sweep_state_t;
  sweep_state_t   state, state_nxt;
  logic [ACC_W:0] sweep_sum;
  logic           sweep_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sweep_sum = {1'b0, ftw_act} + {1'b0, sweep_step};
    sweep_hit = (sweep_sum >= {1'b0, sweep_end});
    case (state)
      S_IDLE:  if (sweep_start) state_nxt = S_RUN;
      S_RUN:   if (tick && sweep_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sweep_busy = (state != S_IDLE);
  assign sweep_done = (state == S_DONE);
  assign busy       = sweep_busy;
`else
  assign busy = 1'b0;
`endif

  // sync outranks the prescaler compare, so it also blocks promotion.
  assign tick      = en & (cnt == div) & ~sync;
  assign ftw_ready = ~pend_full & ~rst & ~busy;
  assign capture   = ftw_valid & ftw_ready;
  // A sweep owns ftw_act; a pending word waits until the sweep has finished.
  assign promote   = tick & pend_full & ~busy;
  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign y_stb     = stb_dly[SINE_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ftw_act   <= '0;
      ftw_pend  <= '0;
      pend_full <= 1'b0;
      x         <= '0;
      x_stb     <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (sync) begin
        acc   <= '0;
        cnt   <= '0;
        x_stb <= 1'b0;
        wrap  <= 1'b0;
      end else if (tick) begin
        cnt   <= '0;
        acc   <= acc_sum[ACC_W-1:0];
        x     <= acc_sum[ACC_W-1 -: PHASE_W] + poff;
        x_stb <= 1'b1;
        wrap  <= acc_sum[ACC_W];
      end else begin
        if (en) cnt <= cnt + 1'b1;
        x_stb <= 1'b0;
        wrap  <= 1'b0;
      end

`ifdef DDS_SWEEP_EN
      if (tick && state == S_RUN)
        ftw_act <= sweep_hit ? sweep_end : sweep_sum[ACC_W-1:0];
      else if (promote)
        ftw_act <= ftw_pend;
`else
      if (promote)
        ftw_act <= ftw_pend;
`endif

      // capture needs an empty buffer and promote a full one, never both.
      if (capture) begin
        ftw_pend  <= ftw_in;
        pend_full <= 1'b1;
      end else if (promote) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stb_dly <= '0;
    end else begin
      stb_dly[0] <= x_stb;
      for (int unsigned i = 1; i < SINE_LAT; i++)
        stb_dly[i] <= stb_dly[i-1];
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div = '0;
  logic [31:0] ftw_in = '0;
  logic        ftw_valid = 1'b0;
  logic        ftw_ready;
  logic [9:0]  poff = '0;
  logic        sync = 1'b0;
  logic [9:0]  x;
  logic        x_stb;
  logic        y_stb;
  logic        wrap;
`ifdef DDS_SWEEP_EN
  logic [31:0] sweep_step = '0;
  logic [31:0] sweep_end = '0;
  logic        sweep_start = 1'b0;
  logic        sweep_busy;
  logic        sweep_done;
`endif

  always #5 clk = ~clk;

  dds_phase_gen #(.ACC_W(32), .PHASE_W(10), .DIV_W(16), .SINE_LAT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .ftw_in(ftw_in),
    .ftw_valid(ftw_valid), .ftw_ready(ftw_ready), .poff(poff), .sync(sync),
    .x(x), .x_stb(x_stb), .y_stb(y_stb), .wrap(wrap)
`ifdef DDS_SWEEP_EN
    , .sweep_step(sweep_step), .sweep_end(sweep_end), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: sample-level behaviour in plain arithmetic.
  longint unsigned m_acc, m_ftw;
  int              m_cnt, m_x;
  bit              m_stb, m_wrap, m_y;
  longint unsigned pq[$];   // pending tuning words (at most one)
  bit              sq[$];   // x_stb history feeding y_stb

  task automatic model_step();
    bit tk, rdy;
    longint unsigned s;
    if (rst) begin
      m_acc = 0; m_ftw = 0; m_cnt = 0; m_x = 0;
      m_stb = 0; m_wrap = 0; m_y = 0;
      pq.delete();
      sq = '{1'b0, 1'b0};
    end else begin
      rdy  = (pq.size() == 0);
      tk   = en && (m_cnt == int'(div)) && !sync;
      m_y  = sq.pop_front();
      if (sync) begin
        m_acc = 0; m_cnt = 0; m_stb = 0; m_wrap = 0;
      end else if (tk) begin
        s      = m_acc + m_ftw;
        m_wrap = (s >= 64'h1_0000_0000);
        m_acc  = s % 64'h1_0000_0000;
        m_x    = int'(((m_acc / 4194304) + longint'(poff)) % 1024);
        m_stb  = 1;
        m_cnt  = 0;
        if (pq.size() > 0) m_ftw = pq.pop_front();
      end else begin
        m_stb = 0; m_wrap = 0;
        if (en) m_cnt = (m_cnt + 1) % 65536;
      end
      if (ftw_valid && rdy) pq.push_back(longint'(ftw_in));
      sq.push_back(m_stb);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("x", longint'(x), longint'(m_x));
    check("x_stb", longint'(x_stb), longint'(m_stb));
    check("y_stb", longint'(y_stb), longint'(m_y));
    check("wrap", longint'(wrap), longint'(m_wrap));
    check("ftw_ready", longint'(ftw_ready), longint'((pq.size() == 0) && !rst));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; div = 0; ftw_valid = 0; ftw_in = 0; poff = 0; sync = 0;
    cycle();
    rst = 0;
  endtask

  typedef struct {
    bit          rst, en;
    logic [15:0] div;
    bit          valid;
    logic [31:0] ftw;
    logic [9:0]  poff;
    bit          sync;
    int          ex;
    bit          estb, ey, ewrap, erdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int wraps, n_stb, last, done_at, dones;

    tbl[0]  = '{1, 0, 0, 0, 32'h0,         0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 32'h0040_0000, 0, 0,   0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 32'h0,         0, 0,   0, 1, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0, 32'h0,         0, 0,   1, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0, 32'h0,         0, 0,   2, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 32'h0,         0, 0,   2, 0, 1, 0, 1};
    tbl[6]  = '{0, 1, 3, 0, 32'h0,         0, 0,   2, 0, 1, 0, 1};
    tbl[7]  = '{0, 1, 3, 0, 32'h0,         0, 0,   2, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 3, 0, 32'h0,         0, 0,   2, 0, 0, 0, 1};
    tbl[9]  = '{0, 1, 3, 0, 32'h0,         0, 0,   3, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 3, 0, 32'h0,         5, 1,   3, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 32'h0,         5, 0,   6, 1, 1, 0, 1};
    tbl[12] = '{0, 1, 0, 1, 32'h8000_0000, 5, 0,   7, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 32'h0,         5, 0,   8, 1, 1, 0, 1};
    tbl[14] = '{0, 1, 0, 0, 32'h0,         5, 0, 520, 1, 1, 0, 1};
    tbl[15] = '{0, 1, 0, 0, 32'h0,         5, 0,   8, 1, 1, 1, 1};

    // Directed vectors: reset, promotion latency, prescaler, en hold, sync,
    // capture-on-tick, delayed promotion and accumulator overflow.
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; div = tbl[i].div;
      ftw_valid = tbl[i].valid; ftw_in = tbl[i].ftw;
      poff = tbl[i].poff; sync = tbl[i].sync;
      cycle();
      check($sformatf("tbl%0d_x", i), longint'(x), longint'(tbl[i].ex));
      check($sformatf("tbl%0d_x_stb", i), longint'(x_stb), longint'(tbl[i].estb));
      check($sformatf("tbl%0d_y_stb", i), longint'(y_stb), longint'(tbl[i].ey));
      check($sformatf("tbl%0d_wrap", i), longint'(wrap), longint'(tbl[i].ewrap));
      check($sformatf("tbl%0d_ready", i), longint'(ftw_ready), longint'(tbl[i].erdy));
    end

    // Randomized traffic against the model.
    rst = 0; ftw_valid = 0; sync = 0;
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 19) == 0) div = 16'($urandom_range(0, 4));
      sync      = ($urandom_range(0, 99) < 3);
      ftw_valid = ($urandom_range(0, 99) < 25);
      ftw_in    = $urandom;
      poff      = 10'($urandom_range(0, 1023));
      cycle();
    end

    // Wrap cadence: x steps by 1 per sample, overflow every 1024 samples.
    do_reset();
    ftw_valid = 1; ftw_in = 32'h0040_0000;
    cycle();
    ftw_valid = 0; en = 1; div = 0;
    wraps = 0; n_stb = 0; last = 0;
    for (int i = 0; i < 4000 && wraps < 3; i++) begin
      cycle();
      if (x_stb) n_stb++;
      if (wrap) begin
        check("wrap_x_zero", longint'(x), 0);
        if (wraps > 0) check("wrap_spacing", longint'(n_stb - last), 1024);
        last = n_stb;
        wraps++;
      end
    end
    check("wrap_count", longint'(wraps), 3);

    // Zero tuning word with offset: every sample lands on poff.
    do_reset();
    poff = 10'd256; en = 1; div = 1; sync = 1;
    cycle();
    sync = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (x_stb) check("poff_x", longint'(x), 256);
    end

    // Reset with a word pending: the pending word must be discarded.
    do_reset();
    ftw_valid = 1; ftw_in = 32'h1000_0000;
    cycle();
    ftw_valid = 0; en = 1;
    cycle();
    cycle();
    check("pre_rst_x", longint'(x), 64);
    en = 0; ftw_valid = 1; ftw_in = 32'h2000_0000;
    cycle();
    ftw_valid = 0;
    check("pend_ready_low", longint'(ftw_ready), 0);
    rst = 1;
    cycle();
    check("rst_x", longint'(x), 0);
    check("rst_x_stb", longint'(x_stb), 0);
    check("rst_y_stb", longint'(y_stb), 0);
    check("rst_wrap", longint'(wrap), 0);
    rst = 0;
    #1;
    check("ready_after_rst", longint'(ftw_ready), 1);
    en = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("discard_x", longint'(x), 0);
    end

`ifdef DDS_SWEEP_EN
    // Sweep 0 -> 0x100, 0x200, 0x300, clamp 0x350 on the fourth tick.
    do_reset();
    sweep_step = 32'h100; sweep_end = 32'h350; sweep_start = 1; en = 0; div = 0;
    @(posedge clk); #1;
    sweep_start = 0;
    check("sweep_busy_start", longint'(sweep_busy), 1);
    check("sweep_ready_low", longint'(ftw_ready), 0);
    en = 1; done_at = -1; dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (sweep_done) begin
        dones++;
        if (done_at < 0) done_at = i;
      end
    end
    check("sweep_done_at", longint'(done_at), 3);
    check("sweep_done_once", longint'(dones), 1);
    check("sweep_busy_end", longint'(sweep_busy), 0);
    check("sweep_ready_end", longint'(ftw_ready), 1);
`else
    done_at = 0; dones = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
